// File: rtl/serial_deserializer_pkg.sv
// Shared types and width helpers for the serial deserializer slice.
// Widths are functions of the block parameters so every file derives them the same way.
package serial_deser_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HUNT    = 1'b1
  } state_e;

  // A bit counter needs at least one bit even when a word is a single bit wide.
  function automatic int cnt_width(input int bits);
    return (bits > 32'sd1) ? $clog2(bits) : 32'sd1;
  endfunction

  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 32'sd1;
  endfunction

  localparam int DEF_BITS  = 32'sd5;
  localparam int DEF_DEPTH = 32'sd2;
  localparam int CNT_W     = cnt_width(DEF_BITS);
  localparam int LVL_W     = lvl_width(DEF_DEPTH);

endpackage

// File: rtl/serial_deserializer_if.sv
// Serial input, parallel output and status bundle of the deserializer.
// master drives the bit stream and consumes words; slave is the deserializer.
interface serial_deserializer_if
  import serial_deser_pkg::*;
#(
  parameter int BITS  = DEF_BITS,
  parameter int DEPTH = DEF_DEPTH
) ();

  localparam int LW = lvl_width(DEPTH);

  logic            ena;
  logic            sin_valid;
  logic            sin;
  logic            sin_eos;
  logic [BITS-1:0] dout;
  logic            dout_valid;
  logic            dout_ready;
  logic [LW-1:0]   level;
  logic            frame_err;
  logic            overflow;
  logic            clr_err;

  modport master (
    output ena, sin_valid, sin, sin_eos, dout_ready, clr_err,
    input  dout, dout_valid, level, frame_err, overflow
  );

  modport slave (
    input  ena, sin_valid, sin, sin_eos, dout_ready, clr_err,
    output dout, dout_valid, level, frame_err, overflow
  );

endinterface

// File: rtl/serial_deserializer_sync_fifo_fwft.sv
// First-word-fall-through FIFO with a registered head word.
// Push while full is only accepted when a pop frees the slot in the same cycle.
module sync_fifo_fwft
  import serial_deser_pkg::*;
#(
  parameter int WIDTH = DEF_BITS,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [lvl_width(DEPTH)-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = lvl_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    rd_nxt_s;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             empty_s, full_s, do_push_s, do_pop_s;

  // Next-state for storage, pointers, occupancy and the registered head word.
  always_comb begin
    empty_s   = (level_q == {LW{1'b0}});
    full_s    = (level_q == LW'(DEPTH));
    do_pop_s  = pop & ~empty_s;
    do_push_s = push & (~full_s | do_pop_s);
    rd_nxt_s  = rd_ptr_q + 1'b1;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    dout_d    = dout_q;

    if (do_push_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    // The head register must already hold the next word when a pop retires the current one.
    if (do_pop_s) begin
      rd_ptr_d = rd_nxt_s;
      if (level_q > LW'(32'd1)) begin
        dout_d = mem_q[rd_nxt_s];
      end else if (do_push_s) begin
        dout_d = din;
      end else begin
        dout_d = dout_q;
      end
    end else if (do_push_s && empty_s) begin
      dout_d = din;
    end else begin
      dout_d = dout_q;
    end

    case ({do_push_s, do_pop_s})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
    end
  end

  assign dout  = dout_q;
  assign empty = empty_s;
  assign full  = full_s;
  assign level = level_q;

endmodule

// File: rtl/serial_deserializer.sv
// Rebuilds LSB-first serial words framed by an end-of-shift marker and queues them
// in a FWFT FIFO; framing errors and dropped words raise sticky flags.
module serial_deserializer
  import serial_deser_pkg::*;
#(
  parameter int BITS  = DEF_BITS,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_deserializer_if.slave  bus
);

  localparam int CW = cnt_width(BITS);
  localparam int LW = lvl_width(DEPTH);

  localparam logic [0:0] ST_COLLECT = COLLECT;
  localparam logic [0:0] ST_HUNT    = HUNT;

  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] shreg_q, shreg_d;
  logic            frame_err_q, frame_err_d;
  logic            overflow_q, overflow_d;
  logic [BITS-1:0] word_s;
  logic            sample_s, last_s, push_s, ferr_ev_s, ovf_ev_s, pop_s;
  logic            empty_s, full_s;
  logic [LW-1:0]   level_s;

  // Framing FSM, shift register and sticky error flags.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    push_s    = 1'b0;
    ferr_ev_s = 1'b0;
    sample_s  = bus.ena & bus.sin_valid;
    last_s    = (cnt_q == CW'(BITS - 1));
    // The final bit is taken straight from the line so the word can be pushed on its own edge.
    word_s           = shreg_q;
    word_s[BITS-1]   = bus.sin;

    case (state_q)
      ST_COLLECT: begin
        if (sample_s) begin
          shreg_d[cnt_q] = bus.sin;
          if (bus.sin_eos) begin
            cnt_d = '0;
            if (last_s) begin
              push_s = 1'b1;
            end else begin
              ferr_ev_s = 1'b1;
            end
          end else if (last_s) begin
            ferr_ev_s = 1'b1;
            cnt_d     = '0;
            state_d   = ST_HUNT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_HUNT: begin
        if (sample_s && bus.sin_eos) begin
          state_d = ST_COLLECT;
          cnt_d   = '0;
        end else begin
          state_d = ST_HUNT;
        end
      end
      default: begin
        state_d = ST_COLLECT;
        cnt_d   = '0;
      end
    endcase

    pop_s       = ~empty_s & bus.dout_ready;
    ovf_ev_s    = push_s & full_s & ~pop_s;
    frame_err_d = (frame_err_q & ~bus.clr_err) | ferr_ev_s;
    overflow_d  = (overflow_q & ~bus.clr_err) | ovf_ev_s;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_COLLECT;
      cnt_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (word_s),
    .dout  (bus.dout),
    .empty (empty_s),
    .full  (full_s),
    .level (level_s)
  );

  assign bus.dout_valid = ~empty_s;
  assign bus.level      = level_s;
  assign bus.frame_err  = frame_err_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench: directed scenarios plus a random run against a queue-based
// reference model of framing, FIFO and sticky flags.
module tb_serial_deserializer;
  import serial_deser_pkg::*;

  localparam int BITS  = 5;
  localparam int DEPTH = 2;
  localparam int LW    = lvl_width(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_deserializer_if #(.BITS(BITS), .DEPTH(DEPTH)) bus ();
  serial_deserializer #(.BITS(BITS), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  bit              m_bits[$];
  bit              m_hunt;
  logic [BITS-1:0] mq[$];
  bit              m_ferr, m_ovf;
  logic [BITS-1:0] got[$];
  logic [BITS-1:0] exp_out[$];

  task automatic model_clear();
    m_bits.delete(); mq.delete(); got.delete(); exp_out.delete();
    m_hunt = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ena = 1'b0; bus.sin_valid = 1'b0; bus.sin = 1'b0; bus.sin_eos = 1'b0;
    bus.dout_ready = 1'b0; bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
  endtask

  // One clock: drive inputs, record any word the DUT hands over, advance the model.
  task automatic step(input logic e, input logic v, input logic s, input logic eos,
                      input logic rdy, input logic clr);
    logic [BITS-1:0] w;
    bit pop, push, ferr_ev, ovf_ev;
    bus.ena = e; bus.sin_valid = v; bus.sin = s; bus.sin_eos = eos;
    bus.dout_ready = rdy; bus.clr_err = clr;
    #1;
    if (bus.dout_valid === 1'b1 && rdy) got.push_back(bus.dout);
    pop = (mq.size() > 0) && rdy;
    push = 1'b0; ferr_ev = 1'b0; w = '0;
    if (e && v) begin
      if (m_hunt) begin
        if (eos) m_hunt = 1'b0;
      end else begin
        m_bits.push_back(s);
        if (eos || m_bits.size() == BITS) begin
          if (eos && m_bits.size() == BITS) begin
            foreach (m_bits[i]) w[i] = m_bits[i];
            push = 1'b1;
          end else begin
            ferr_ev = 1'b1;
            if (!eos) m_hunt = 1'b1;
          end
          m_bits.delete();
        end
      end
    end
    ovf_ev = push && (mq.size() == DEPTH) && !pop;
    m_ferr = (m_ferr && !clr) || ferr_ev;
    m_ovf  = (m_ovf && !clr) || ovf_ev;
    if (pop) exp_out.push_back(mq.pop_front());
    if (push && !ovf_ev) mq.push_back(w);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [BITS-1:0] w, input int n, input int eos_at,
                      input logic rdy, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 1) == 1)
        step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rdy, 1'b0);
      step(1'b1, 1'b1, w[i], (i == eos_at), rdy, 1'b0);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (bus.dout_valid !== 1'b0 || bus.level !== '0 || bus.frame_err !== 1'b0 || bus.overflow !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle: valid=%b level=%0d ferr=%b ovf=%b, expected all 0",
                 bus.dout_valid, bus.level, bus.frame_err, bus.overflow);
      end
    end
  endtask

  task automatic test_word();
    send(5'b10110, BITS, BITS - 1, 1'b1, 1'b0);
    vectors++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 5'h16 || bus.frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL word_out: valid=%b dout=%h ferr=%b, expected 1 16 0", bus.dout_valid, bus.dout, bus.frame_err);
    end
    idle(1, 1'b1);
    vectors++;
    if (bus.dout_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL word_one_cycle: valid=%b, expected 0", bus.dout_valid);
    end
  endtask

  task automatic test_overflow();
    got.delete();
    send(5'h01, BITS, BITS - 1, 1'b0, 1'b0);
    send(5'h02, BITS, BITS - 1, 1'b0, 1'b0);
    send(5'h03, BITS, BITS - 1, 1'b0, 1'b0);
    vectors++;
    if (bus.level !== LW'(2) || bus.overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_set: level=%0d ovf=%b, expected 2 1", bus.level, bus.overflow);
    end
    idle(4, 1'b1);
    vectors++;
    if (got.size() != 2 || got[0] !== 5'h01 || got[1] !== 5'h02) begin
      miscompares++;
      $display("FAIL overflow_drain: got %p, expected 01 02", got);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    vectors++;
    if (bus.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_clear: ovf=%b, expected 0", bus.overflow);
    end
  endtask

  task automatic test_early_eos();
    got.delete();
    send(5'h07, 3, 2, 1'b1, 1'b0);
    vectors++;
    if (bus.frame_err !== 1'b1 || bus.dout_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL early_eos: ferr=%b valid=%b, expected 1 0", bus.frame_err, bus.dout_valid);
    end
    send(5'h1F, BITS, BITS - 1, 1'b1, 1'b0);
    idle(2, 1'b1);
    vectors++;
    if (got.size() != 1 || got[0] !== 5'h1F) begin
      miscompares++;
      $display("FAIL early_eos_next: got %p, expected 1f", got);
    end
  endtask

  task automatic test_missing_eos();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    got.delete();
    send(5'($urandom), BITS, -1, 1'b1, 1'b0);
    vectors++;
    if (bus.frame_err !== 1'b1) begin
      miscompares++;
      $display("FAIL missing_eos: ferr=%b, expected 1", bus.frame_err);
    end
    send(5'($urandom), 3, -1, 1'b1, 1'b0);
    send(5'($urandom), 1, 0, 1'b1, 1'b0);
    send(5'h0A, BITS, BITS - 1, 1'b1, 1'b0);
    idle(2, 1'b1);
    vectors++;
    if (got.size() != 1 || got[0] !== 5'h0A) begin
      miscompares++;
      $display("FAIL missing_eos_out: got %p, expected 0a", got);
    end
  endtask

  task automatic test_edge();
    logic [BITS-1:0] w0, w1, w2;
    w0 = 5'($urandom); w1 = 5'($urandom); w2 = 5'($urandom);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    got.delete();
    send(w0, BITS, BITS - 1, 1'b0, 1'b0);
    send(w1, BITS, BITS - 1, 1'b0, 1'b0);
    send(w2, BITS - 1, -1, 1'b0, 1'b0);
    step(1'b1, 1'b1, w2[BITS-1], 1'b1, 1'b1, 1'b0);
    vectors++;
    if (bus.level !== LW'(2) || bus.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL full_push_pop: level=%0d ovf=%b, expected 2 0", bus.level, bus.overflow);
    end
    idle(3, 1'b1);
    vectors++;
    if (got.size() != 3 || got[0] !== w0 || got[1] !== w1 || got[2] !== w2) begin
      miscompares++;
      $display("FAIL full_push_pop_order: got %p, expected %h %h %h", got, w0, w1, w2);
    end

    send(5'h1B, 3, -1, 1'b1, 1'b0);
    do_reset();
    send(5'h15, BITS, BITS - 1, 1'b1, 1'b0);
    idle(2, 1'b1);
    vectors++;
    if (got.size() != 1 || got[0] !== 5'h15 || bus.frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midword: got %p ferr=%b, expected 15 0", got, bus.frame_err);
    end

    got.delete();
    w0 = 5'($urandom);
    send(w0, BITS, BITS - 1, 1'b1, 1'b1);
    idle(2, 1'b1);
    vectors++;
    if (got.size() != 1 || got[0] !== w0 || bus.frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL ena_gaps: got %p ferr=%b, expected %h 0", got, bus.frame_err, w0);
    end
  endtask

  task automatic test_random();
    logic [LW-1:0] exp_lvl;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
      exp_lvl = LW'(mq.size());
      vectors++;
      if (bus.level !== exp_lvl || bus.dout_valid !== (mq.size() > 0) ||
          bus.frame_err !== m_ferr || bus.overflow !== m_ovf ||
          (mq.size() > 0 && bus.dout !== mq[0])) begin
        miscompares++;
        $display("FAIL random_cycle%0d: level=%0d valid=%b dout=%h ferr=%b ovf=%b, expected %0d %b %h %b %b",
                 c, bus.level, bus.dout_valid, bus.dout, bus.frame_err, bus.overflow,
                 exp_lvl, (mq.size() > 0), (mq.size() > 0) ? mq[0] : 5'h00, m_ferr, m_ovf);
      end
    end
    idle(4, 1'b1);
    vectors++;
    if (got != exp_out) begin
      miscompares++;
      $display("FAIL random_stream: got %0d words, expected %0d words", got.size(), exp_out.size());
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_overflow();
    test_early_eos();
    test_missing_eos();
    test_edge();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
